// File: rtl/ulpi_reg_read.sv
// ---------------------------------------------------------------------------
// ulpi_reg_read
//
// ULPI immediate register-read initiator for a USB3300-class PHY. A one-cycle
// RD request issues the RegRead TX CMD (8'b11_aaaaaa). The block then follows
// the NXT/DIR turnaround handshake, captures the byte the PHY returns and
// presents it with a one-cycle `valid` strobe.
//
// A PHY-initiated abort (DIR rising while the command is on the bus, or DIR
// falling where read data is expected) re-issues the same command, up to
// RETRY_MAX times. Running out of retries, or waiting too long in any
// handshake state, ends the read with a one-cycle `error` strobe.
//
// Parameters
//   RETRY_MAX    re-issues allowed after aborts before `error` (0 = none)
//   TIMEOUT      max cycles spent waiting in one handshake state
//
// Ports
//   clk          ULPI 60 MHz clock, rising edge
//   rst          asynchronous reset, active low
//   RD           read request strobe, accepted only while busy = 0
//   ADDR         6-bit register address, latched with RD
//   DATA         last captured register value
//   valid        one-cycle pulse when DATA is updated
//   error        one-cycle pulse when the read fails
//   busy         high from RD acceptance until valid/error
//   DIR, NXT     PHY direction / next handshake inputs
//   ULPI_DATA_I  ULPI data bus as driven by the PHY
//   ULPI_DATA_O  link-driven ULPI data (TX CMD)
//   ULPI_OE      link output enable for the shared data bus
// ---------------------------------------------------------------------------
module ulpi_reg_read #(
  parameter int RETRY_MAX = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RD,
  input  logic [5:0] ADDR,
  output logic [7:0] DATA,
  output logic       valid,
  output logic       error,
  output logic       busy,
  input  logic       DIR,
  input  logic       NXT,
  input  logic [7:0] ULPI_DATA_I,
  output logic [7:0] ULPI_DATA_O,
  output logic       ULPI_OE
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int RTY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  // A wait state gives up on the edge that would take the counter to TIMEOUT.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BUS,
    CMD,
    TURN1,
    RDATA,
    TURN2,
    ABORT
  } state_t;

  state_t           state;
  logic [5:0]       addr_q;
  logic [RTY_W-1:0] retry_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic tmo_hit;
  logic retry_ok;

  assign tmo_hit  = (tmo_cnt == TMO_LAST);
  assign retry_ok = (int'(retry_cnt) < RETRY_MAX);

  // NOTE: ULPI_OE is a combinational function of the registered state and
  // the live DIR pin. When the PHY grabs the bus mid-command, the link
  // releases the bus in that same cycle instead of one clock later. Both
  // outputs are fully assigned in every state, so no latch can form.
  assign ULPI_OE     = (state == CMD) && !DIR;
  assign ULPI_DATA_O = (state == CMD) ? {2'b11, addr_q} : 8'h00;

  // NOTE: all state and registered outputs use non-blocking assignments, so
  // every branch reads the values from before the edge. That ordering is
  // what lets valid/error be cleared by default at the top of the block and
  // then set in one branch, without a race.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      retry_cnt <= '0;
      tmo_cnt   <= '0;
      DATA      <= 8'h00;
      valid     <= 1'b0;
      error     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid <= 1'b0;
      error <= 1'b0;

      unique case (state)
        IDLE: begin
          if (RD) begin
            addr_q    <= ADDR;
            retry_cnt <= '0;
            tmo_cnt   <= '0;
            busy      <= 1'b1;
            state     <= WAIT_BUS;
          end
        end

        // The PHY may be streaming RX CMDs; the command can only start once
        // it hands the bus back.
        WAIT_BUS: begin
          if (!DIR) begin
            tmo_cnt <= '0;
            state   <= CMD;
          end else if (tmo_hit) begin
            tmo_cnt <= '0;
            error   <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        // DIR wins over NXT: a PHY that asserts both has aborted the command.
        CMD: begin
          if (DIR) begin
            tmo_cnt <= '0;
            state   <= ABORT;
          end else if (NXT) begin
            tmo_cnt <= '0;
            state   <= TURN1;
          end else if (tmo_hit) begin
            tmo_cnt <= '0;
            error   <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        // First DIR-high cycle is the bus turnaround; no data on it.
        TURN1: begin
          if (DIR) begin
            tmo_cnt <= '0;
            state   <= RDATA;
          end else if (tmo_hit) begin
            tmo_cnt <= '0;
            error   <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        // Single-cycle state. If DIR dropped, the PHY abandoned the read.
        RDATA: begin
          tmo_cnt <= '0;
          if (DIR) begin
            DATA  <= ULPI_DATA_I;
            state <= TURN2;
          end else begin
            state <= ABORT;
          end
        end

        TURN2: begin
          if (!DIR) begin
            tmo_cnt <= '0;
            valid   <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (tmo_hit) begin
            tmo_cnt <= '0;
            error   <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        // Retry with the address latched at acceptance once the PHY
        // releases the bus.
        ABORT: begin
          if (!DIR) begin
            tmo_cnt <= '0;
            if (retry_ok) begin
              retry_cnt <= retry_cnt + RTY_W'(1);
              state     <= CMD;
            end else begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (tmo_hit) begin
            tmo_cnt <= '0;
            error   <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        default: begin
          tmo_cnt <= '0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ulpi_reg_read.sv
// ---------------------------------------------------------------------------
// tb_ulpi_reg_read
//
// Directed bench for ulpi_reg_read. It plays the PHY side of the ULPI bus
// cycle by cycle and compares outputs against hand-computed values. Inputs
// are driven 1 time unit after the rising edge; outputs are sampled 1 unit
// later, well away from the edge. A negedge monitor counts valid/error
// pulses so that pulse counts and exclusivity can be checked.
// ---------------------------------------------------------------------------
module tb_ulpi_reg_read;

  logic       clk = 1'b0;
  logic       rst;
  logic       RD;
  logic [5:0] ADDR;
  logic [7:0] DATA;
  logic       valid;
  logic       error;
  logic       busy;
  logic       DIR;
  logic       NXT;
  logic [7:0] ULPI_DATA_I;
  logic [7:0] ULPI_DATA_O;
  logic       ULPI_OE;

  int checks   = 0;
  int failures = 0;
  int n_valid  = 0;
  int n_error  = 0;
  int n_both   = 0;

  ulpi_reg_read #(
    .RETRY_MAX(3),
    .TIMEOUT  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RD         (RD),
    .ADDR       (ADDR),
    .DATA       (DATA),
    .valid      (valid),
    .error      (error),
    .busy       (busy),
    .DIR        (DIR),
    .NXT        (NXT),
    .ULPI_DATA_I(ULPI_DATA_I),
    .ULPI_DATA_O(ULPI_DATA_O),
    .ULPI_OE    (ULPI_OE)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) n_valid++;
    if (error) n_error++;
    if (valid && error) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in a cycle where the DUT is in CMD with DIR=0. Plays a clean
  // PHY response: NXT, turnaround, data byte, one extra DIR cycle, release.
  task automatic phy_answer(input logic [7:0] d, input string tag);
    int v0;
    int e0;
    v0 = n_valid;
    e0 = n_error;
    NXT = 1'b1;
    #1 check({tag, "_oe_at_nxt"}, ULPI_OE, 1);
    step();
    NXT = 1'b0;
    DIR = 1'b1;
    #1 check({tag, "_oe_turn"}, ULPI_OE, 0);
    check({tag, "_dout_turn"}, ULPI_DATA_O, 8'h00);
    step();
    ULPI_DATA_I = d;
    step();
    ULPI_DATA_I = 8'hEE;
    #1 check({tag, "_busy_turn2"}, busy, 1);
    check({tag, "_data_latched"}, DATA, d);
    step();
    DIR = 1'b0;
    ULPI_DATA_I = 8'h00;
    step();
    check({tag, "_valid"}, valid, 1);
    check({tag, "_data"}, DATA, d);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_no_error"}, error, 0);
    step();
    check({tag, "_valid_width"}, valid, 0);
    check({tag, "_valid_count"}, n_valid - v0, 1);
    check({tag, "_error_count"}, n_error - e0, 0);
  endtask

  initial begin
    int v0;
    int e0;

    rst         = 1'b0;
    RD          = 1'b0;
    ADDR        = 6'h00;
    DIR         = 1'b0;
    NXT         = 1'b0;
    ULPI_DATA_I = 8'h00;

    // Reset state
    repeat (3) step();
    check("rst_data", DATA, 8'h00);
    check("rst_valid", valid, 0);
    check("rst_error", error, 0);
    check("rst_busy", busy, 0);
    check("rst_oe", ULPI_OE, 0);
    check("rst_dout", ULPI_DATA_O, 8'h00);
    rst = 1'b1;
    step();

    // Basic read: ADDR 0x1A -> TX CMD 0xDA, NXT two cycles after CMD, byte 0x3A
    ADDR = 6'h1A;
    RD   = 1'b1;
    step();
    RD = 1'b0;
    #1 check("basic_busy_rise", busy, 1);
    check("basic_oe_waitbus", ULPI_OE, 0);
    step();
    check("basic_cmd_oe0", ULPI_OE, 1);
    check("basic_cmd_dout0", ULPI_DATA_O, 8'hDA);
    step();
    check("basic_cmd_oe1", ULPI_OE, 1);
    check("basic_cmd_dout1", ULPI_DATA_O, 8'hDA);
    step();
    check("basic_cmd_dout2", ULPI_DATA_O, 8'hDA);
    phy_answer(8'h3A, "basic");

    // Bus busy: DIR high at RD, released 4 cycles later; ADDR 0x05 -> 0xC5.
    // A second RD while busy must be ignored.
    DIR  = 1'b1;
    ADDR = 6'h05;
    RD   = 1'b1;
    step();
    RD = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        RD   = 1'b1;
        ADDR = 6'h3F;
      end else begin
        RD = 1'b0;
      end
      #1 check("busbusy_oe_dir", ULPI_OE, 0);
      step();
    end
    RD  = 1'b0;
    DIR = 1'b0;
    #1 check("busbusy_oe_release", ULPI_OE, 0);
    step();
    check("busbusy_cmd_oe", ULPI_OE, 1);
    check("busbusy_cmd_dout", ULPI_DATA_O, 8'hC5);
    phy_answer(8'h77, "busbusy");

    // Abort and retry: ADDR 0x2B -> 0xEB, DIR before NXT on first attempt
    ADDR = 6'h2B;
    RD   = 1'b1;
    step();
    RD = 1'b0;
    step();
    check("abort_cmd_oe", ULPI_OE, 1);
    check("abort_cmd_dout", ULPI_DATA_O, 8'hEB);
    DIR = 1'b1;
    #1 check("abort_oe_drop_same_cycle", ULPI_OE, 0);
    step();
    check("abort_oe_in_abort", ULPI_OE, 0);
    check("abort_busy", busy, 1);
    DIR = 1'b0;
    step();
    check("retry_cmd_oe", ULPI_OE, 1);
    check("retry_cmd_dout", ULPI_DATA_O, 8'hEB);
    phy_answer(8'h55, "retry");

    // Retries exhausted: four consecutive aborts with RETRY_MAX=3
    v0   = n_valid;
    e0   = n_error;
    ADDR = 6'h10;
    RD   = 1'b1;
    step();
    RD = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      check("exhaust_cmd_dout", ULPI_DATA_O, 8'hD0);
      check("exhaust_no_error_yet", error, 0);
      DIR = 1'b1;
      step();
      DIR = 1'b0;
      step();
    end
    check("exhaust_error", error, 1);
    check("exhaust_no_valid", valid, 0);
    check("exhaust_busy", busy, 0);
    check("exhaust_data_kept", DATA, 8'h55);
    check("exhaust_oe", ULPI_OE, 0);
    step();
    check("exhaust_error_width", error, 0);
    check("exhaust_error_count", n_error - e0, 1);
    check("exhaust_valid_count", n_valid - v0, 0);

    // Timeout: NXT never asserted, TIMEOUT=16 -> error 16 cycles after CMD
    ADDR = 6'h3F;
    RD   = 1'b1;
    step();
    RD = 1'b0;
    step();
    check("tmo_cmd_dout", ULPI_DATA_O, 8'hFF);
    for (int k = 0; k < 16; k++) begin
      check("tmo_wait_no_error", error, 0);
      check("tmo_wait_oe", ULPI_OE, 1);
      step();
    end
    check("tmo_error", error, 1);
    check("tmo_oe", ULPI_OE, 0);
    check("tmo_busy", busy, 0);
    check("tmo_data_kept", DATA, 8'h55);
    step();
    check("tmo_error_width", error, 0);

    // Reset mid-read: assert rst while the DUT is in RDATA
    ADDR = 6'h21;
    RD   = 1'b1;
    step();
    RD = 1'b0;
    step();
    check("rstmid_cmd_dout", ULPI_DATA_O, 8'hE1);
    NXT = 1'b1;
    step();
    NXT = 1'b0;
    DIR = 1'b1;
    step();
    v0 = n_valid;
    e0 = n_error;
    ULPI_DATA_I = 8'h99;
    #1 rst = 1'b0;
    #1 check("rstmid_data", DATA, 8'h00);
    check("rstmid_busy", busy, 0);
    check("rstmid_oe", ULPI_OE, 0);
    check("rstmid_dout", ULPI_DATA_O, 8'h00);
    check("rstmid_valid", valid, 0);
    check("rstmid_error", error, 0);
    step();
    DIR = 1'b0;
    ULPI_DATA_I = 8'h00;
    step();
    rst = 1'b1;
    step();
    step();
    check("rstmid_no_valid", n_valid - v0, 0);
    check("rstmid_no_error", n_error - e0, 0);

    // Subsequent read completes normally: ADDR 0x02 -> 0xC2, byte 0xA5
    ADDR = 6'h02;
    RD   = 1'b1;
    step();
    RD = 1'b0;
    step();
    check("after_rst_cmd_dout", ULPI_DATA_O, 8'hC2);
    phy_answer(8'hA5, "after_rst");

    check("valid_error_exclusive", n_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ulpi_reg_read.md
# ulpi_reg_read

ULPI immediate register-read initiator: on a one-cycle request it issues the RegRead TX CMD (`8'b11_aaaaaa`) to the USB3300 PHY and follows the NXT/DIR turnaround handshake. It captures the register byte the PHY returns and presents it with a one-cycle `valid` strobe. It sits beside the register-write block in the ULPI link layer and shares the PHY bus through the top-level data mux driven by `ULPI_OE`. It recovers from PHY-initiated aborts by retrying, and flags an error after a bounded number of retries or on a handshake timeout.

## Interface
- `RETRY_MAX`, default 3: number of re-issues after an abort before `error` is raised (0 means no retry).
- `TIMEOUT`, default 255: maximum cycles spent waiting in any single handshake state. Counter width is `$clog2(TIMEOUT+1)`.

- `clk`  in  1  ULPI 60 MHz clock. All logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `RD`  in  1  read request strobe; one cycle high. Sampled only while `busy`=0.
- `ADDR`  in  6  register address; latched on the cycle `RD` is accepted.
- `DATA`  out  8  captured register value; holds until the next capture.
- `valid`  out  1  one-cycle pulse when `DATA` is updated.
- `error`  out  1  one-cycle pulse when the read fails (retries exhausted or timeout).
- `busy`  out  1  high from `RD` acceptance until the cycle `valid` or `error` pulses.
- `DIR`  in  1  PHY bus direction (1 = PHY drives).
- `NXT`  in  1  PHY next/accept.
- `ULPI_DATA_I`  in  8  ULPI data bus as seen from the PHY.
- `ULPI_DATA_O`  out  8  link-driven ULPI data.
- `ULPI_OE`  out  1  link output enable for the data bus.

## Operation
- FSM states: IDLE, WAIT_BUS, CMD, TURN1, RDATA, TURN2, ABORT.
- **IDLE.** `RD`=1 latches `ADDR`, clears the retry count and goes to WAIT_BUS.
- **WAIT_BUS.**
  - `DIR`=0 → CMD.
  - `DIR`=1 → stay; the PHY owns the bus (RX CMD traffic).
- **CMD.** `ULPI_OE`=1 and `ULPI_DATA_O`=`{2'b11, addr}`, held until the PHY responds.
  - `NXT`=1 and `DIR`=0 → TURN1. `ULPI_OE` drops and `ULPI_DATA_O` returns to 00h on the same edge.
  - `DIR`=1, with any `NXT` → ABORT. `ULPI_OE` drops immediately, combinationally from `DIR`, so there is no bus contention.
- **TURN1.**
  - `DIR`=1 → RDATA; this is the turnaround cycle.
  - `DIR`=0 → stay, subject to timeout.
- **RDATA.**
  - `DIR`=1 → latch `ULPI_DATA_I` into `DATA` and go to TURN2.
  - `DIR`=0 → ABORT.
- **TURN2.**
  - `DIR`=0 → IDLE, pulsing `valid` and dropping `busy`.
  - `DIR`=1 → stay, subject to timeout.
- **ABORT.** Wait for `DIR`=0.
  - Retry count < `RETRY_MAX` → increment it and go to CMD.
  - Otherwise → IDLE with an `error` pulse.
- **Timeout.** A counter clears on every state change. If it reaches `TIMEOUT` in WAIT_BUS, CMD, TURN1, TURN2 or ABORT → IDLE with an `error` pulse, `ULPI_OE`=0 and `DATA` unchanged.
- **Exclusivity.** `valid` and `error` never pulse together. `RD` while `busy`=1 is ignored; it is not queued.
- **Bus ownership.** `ULPI_OE`=1 only in CMD with `DIR`=0. `ULPI_OE` is 0 in every other state and whenever `DIR`=1.
- **Address.** The latched address is reused unchanged on every retry.

## Timing
- **Reset.** Asserting `rst` low at any time gives state IDLE, `DATA`=00h, `valid`=0, `error`=0, `busy`=0, `ULPI_OE`=0, `ULPI_DATA_O`=00h, and clears the retry and timeout counters. A read in progress is dropped silently, with no `error` pulse.
- **Minimum latency.** Take the edge where `RD` is sampled as E0, with `DIR`=0 and the PHY answering immediately. Then:
  - E1: CMD is driven.
  - E2: `NXT` is sampled.
  - E3: `DIR` high is sampled.
  - E4: data is sampled.
  - E5: `DIR` low is sampled.
  - `valid`=1 during the cycle after E5. Total latency: 5 cycles.
- **`busy` window.** `busy` rises in the cycle after E0 and falls in the same cycle that `valid` or `error` is high.
- **`NXT` and `DIR` together in CMD.** Treated as an abort, not an accept.
- **`valid`/`error` width.** Exactly 1 cycle each, registered.

## Test plan
- **Basic read.** `ADDR`=0x1A, `RD` pulsed. PHY asserts `NXT` 2 cycles after CMD appears, then `DIR` for 3 cycles with byte 0x3A in the second `DIR` cycle.
  - Expect `ULPI_DATA_O`=0xDA with `ULPI_OE`=1 until `NXT`.
  - Expect `DATA`=0x3A, `valid` pulsed once, `busy` low afterwards.
- **Bus busy.** `DIR`=1 when `RD` arrives, released 4 cycles later.
  - Expect no `ULPI_OE` while `DIR`=1.
  - Expect CMD 0xC5 (`ADDR`=0x05) driven one cycle after `DIR` falls, then normal completion.
- **Abort and retry.** PHY raises `DIR` in CMD before `NXT` on the first attempt; the second attempt is normal with byte 0x55.
  - Expect `ULPI_OE` to drop in the same cycle as `DIR`.
  - Expect CMD to be re-driven after `DIR` falls, then `DATA`=0x55 and `valid`.
- **Retries exhausted.** Four consecutive aborts with `RETRY_MAX`=3.
  - Expect exactly one `error` pulse, no `valid`, and `DATA` keeping its previous value.
- **Timeout.** `NXT` is never asserted, with `TIMEOUT`=16.
  - Expect `error` 16 cycles after CMD starts, then `ULPI_OE`=0 and `busy`=0.
- **Reset mid-read.** `rst` driven low during RDATA.
  - Expect all outputs at reset values immediately, with no `valid` and no `error`.
  - Expect a subsequent read to complete normally.
